// File: rtl/zpu_sd_pkg.sv
// Shared constants for the ZPU <-> hps_io SD bridge: sector address width
// and the bit layout of the ZPU_IN2 status byte.
package zpu_sd_pkg;
    localparam int SECTOR_AW        = 9;
    localparam int IN2_IO_DONE      = 0;
    localparam int IN2_MOUNTED      = 1;
    localparam int IN2_FILENO_LSB   = 2;
    localparam int IN2_FILETYPE_LSB = 5;
    localparam int IN2_READONLY     = 7;

    typedef logic [SECTOR_AW-1:0] sector_addr_t;
endpackage

// File: rtl/zpu_sd_bridge_if.sv
// hps_io side of the bridge: block request handshake, sector buffer port and
// image-mount information. master = bridge, slave = hps_io.
interface zpu_sd_bridge_if;
    import zpu_sd_pkg::*;

    logic [31:0]  sd_lba;
    logic         sd_rd;
    logic         sd_wr;
    logic         sd_ack;
    sector_addr_t sd_buff_addr;
    logic [7:0]   sd_buff_dout;
    logic         sd_buff_wr;
    logic [7:0]   sd_buff_din;
    logic         img_mounted;
    logic [63:0]  img_size;
    logic [7:0]   ioctl_index;

    modport master (
        output sd_lba, sd_rd, sd_wr, sd_buff_din,
        input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
        input  img_mounted, img_size, ioctl_index
    );

    modport slave (
        input  sd_lba, sd_rd, sd_wr, sd_buff_din,
        output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
        output img_mounted, img_size, ioctl_index
    );
endinterface

// File: rtl/sd_sector_ram.sv
// 512x8 true dual-port sector buffer, single clock, registered reads
// (read-old-data when a port reads the address being written).
module sd_sector_ram
    import zpu_sd_pkg::*;
(
    input  logic         clk_sys,
    input  sector_addr_t addr_a,
    input  logic [7:0]   din_a,
    input  logic         we_a,
    output logic [7:0]   q_a,
    input  sector_addr_t addr_b,
    input  logic [7:0]   din_b,
    input  logic         we_b,
    output logic [7:0]   q_b
);
    logic [7:0] mem [0:(1<<SECTOR_AW)-1];

    always_ff @(posedge clk_sys) begin
        if (we_a) mem[addr_a] <= din_a;
        if (we_b) mem[addr_b] <= din_b;
        q_a <= mem[addr_a];
        q_b <= mem[addr_b];
    end
endmodule

// File: rtl/zpu_sd_bridge.sv
// Bridges ZPU register-mapped disk I/O to the hps_io SD block interface:
// sector buffer, LBA register, rd/wr request handshake and mount status.
module zpu_sd_bridge
    import zpu_sd_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  zpu_lba_sel,
    input  logic                  zpu_block_rd,
    input  logic                  zpu_block_wr,
    input  logic                  zpu_io_wr,
    input  logic                  zpu_data_wr,
    input  logic                  zpu_data_rd,
    input  logic [31:0]           zpu_wdata,
    output logic [7:0]            zpu_in2,
    output logic [31:0]           zpu_in3,
    zpu_sd_bridge_if.master       hps
);
    logic         data_wr_p1, data_wr_p2, data_rd_p1;
    logic         block_rd_p1, block_rd_p2, block_wr_p1, block_wr_p2;
    logic         ack_p1, mnt_p1, resync_done;
    logic         buf_we_p2;
    logic [7:0]   buf_wdata_p2;
    sector_addr_t buf_addr;
    logic [31:0]  sd_lba, filesize;
    logic         sd_rd, sd_wr, io_done, mounted, readonly;
    logic [2:0]   fileno;
    logic [1:0]   filetype;
    logic [7:0]   ram_q_b;

    logic data_wr_edge, data_rd_fall, block_rd_edge, block_wr_edge, ack_fall, mount_edge;
    assign data_wr_edge  = data_wr_p1 & ~data_wr_p2;
    assign data_rd_fall  = data_rd_p1 & ~zpu_data_rd;
    assign block_rd_edge = block_rd_p1 & ~block_rd_p2;
    assign block_wr_edge = block_wr_p1 & ~block_wr_p2;
    assign ack_fall      = ack_p1 & ~hps.sd_ack;
    assign mount_edge    = hps.img_mounted & ~mnt_p1;

    logic unused_ok;
    assign unused_ok = &{1'b0, hps.img_size[63:32], hps.ioctl_index[5:0]};

    // p0 -> p1/p2: strobe sampling, request handshake and status
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            data_wr_p1  <= 1'b0;
            data_wr_p2  <= 1'b0;
            data_rd_p1  <= 1'b0;
            block_rd_p1 <= 1'b0;
            block_rd_p2 <= 1'b0;
            block_wr_p1 <= 1'b0;
            block_wr_p2 <= 1'b0;
            ack_p1      <= 1'b0;
            mnt_p1      <= 1'b0;
            resync_done <= 1'b0;
            buf_we_p2   <= 1'b0;
            buf_addr    <= '0;
            sd_lba      <= '0;
            sd_rd       <= 1'b0;
            sd_wr       <= 1'b0;
            io_done     <= 1'b0;
            mounted     <= 1'b0;
            fileno      <= '0;
            filetype    <= '0;
            readonly    <= 1'b0;
            filesize    <= '0;
        end else begin
            data_wr_p1  <= zpu_data_wr;
            data_wr_p2  <= data_wr_p1;
            data_rd_p1  <= zpu_data_rd;
            block_rd_p1 <= zpu_block_rd;
            block_rd_p2 <= block_rd_p1;
            block_wr_p1 <= zpu_block_wr;
            block_wr_p2 <= block_wr_p1;
            ack_p1      <= hps.sd_ack;
            mnt_p1      <= hps.img_mounted;
            resync_done <= 1'b1;

            buf_we_p2 <= data_wr_edge & ~zpu_lba_sel;
            if (data_wr_edge && zpu_lba_sel) sd_lba <= zpu_wdata;

            // a buffer write advances the address on the same edge the RAM latches it
            if (zpu_io_wr)                      buf_addr <= '0;
            else if (buf_we_p2 || data_rd_fall) buf_addr <= buf_addr + 1'b1;

            if (ack_fall) io_done <= 1'b1;
            if (hps.sd_ack) begin
                sd_rd <= 1'b0;
                sd_wr <= 1'b0;
            end else if (block_rd_edge) begin
                sd_rd   <= 1'b1;
                io_done <= 1'b0;
            end else if (block_wr_edge) begin
                sd_wr   <= 1'b1;
                io_done <= 1'b0;
            end

            if (mount_edge) begin
                fileno   <= '0;
                filetype <= hps.ioctl_index[7:6];
                readonly <= 1'b1;
                filesize <= hps.img_size[31:0];
                mounted  <= ~mounted;
            end else if (!resync_done) begin
                mounted  <= |hps.img_size[31:0];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (data_wr_edge) buf_wdata_p2 <= zpu_wdata[7:0];
    end

    sd_sector_ram u_ram (
        .clk_sys (CLK),
        .addr_a  (hps.sd_buff_addr),
        .din_a   (hps.sd_buff_dout),
        .we_a    (hps.sd_buff_wr),
        .q_a     (hps.sd_buff_din),
        .addr_b  (buf_addr),
        .din_b   (buf_wdata_p2),
        .we_b    (buf_we_p2),
        .q_b     (ram_q_b)
    );

    assign hps.sd_lba = sd_lba;
    assign hps.sd_rd  = sd_rd;
    assign hps.sd_wr  = sd_wr;

    always_comb begin
        zpu_in2 = '0;
        zpu_in2[IN2_IO_DONE]               = io_done;
        zpu_in2[IN2_MOUNTED]               = mounted;
        zpu_in2[IN2_FILENO_LSB +: 3]       = fileno;
        zpu_in2[IN2_FILETYPE_LSB +: 2]     = filetype;
        zpu_in2[IN2_READONLY]              = readonly;
    end

    assign zpu_in3 = zpu_lba_sel ? filesize : {24'b0, ram_q_b};
endmodule

// File: tb/tb_zpu_sd_bridge.sv
// Randomized bench for zpu_sd_bridge against a behavioural model of the
// sector buffer, LBA register, request handshake and mount status.
module tb_zpu_sd_bridge;
    import zpu_sd_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        zpu_lba_sel, zpu_block_rd, zpu_block_wr, zpu_io_wr;
    logic        zpu_data_wr, zpu_data_rd;
    logic [31:0] zpu_wdata;
    logic [7:0]  zpu_in2;
    logic [31:0] zpu_in3;

    zpu_sd_bridge_if hps ();

    zpu_sd_bridge dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .zpu_lba_sel  (zpu_lba_sel),
        .zpu_block_rd (zpu_block_rd),
        .zpu_block_wr (zpu_block_wr),
        .zpu_io_wr    (zpu_io_wr),
        .zpu_data_wr  (zpu_data_wr),
        .zpu_data_rd  (zpu_data_rd),
        .zpu_wdata    (zpu_wdata),
        .zpu_in2      (zpu_in2),
        .zpu_in3      (zpu_in3),
        .hps          (hps)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // reference model state
    logic [7:0]  m_ram [512];
    int          m_addr;
    logic [31:0] m_lba, m_fsize;
    logic        m_done, m_mounted, m_ro;
    logic [1:0]  m_ftype;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    function automatic logic [7:0] exp_in2();
        return {m_ro, m_ftype, 3'b000, m_mounted, m_done};
    endfunction

    task automatic model_reset();
        m_addr = 0; m_lba = 0; m_fsize = 0;
        m_done = 0; m_mounted = 0; m_ro = 0; m_ftype = 0;
    endtask

    task automatic zpu_write(input logic [7:0] b, input int hold);
        zpu_lba_sel = 1'b0;
        zpu_wdata   = {$urandom_range(0, 32'h00FF_FFFF), 8'h00} | {24'h0, b};
        zpu_data_wr = 1'b1;
        tick(hold);
        zpu_data_wr = 1'b0;
        tick(3);
        m_ram[m_addr] = b;
        m_addr = (m_addr + 1) % 512;
    endtask

    task automatic zpu_rd_strobe(input int hold);
        zpu_data_rd = 1'b1;
        tick(hold);
        zpu_data_rd = 1'b0;
        tick();
        m_addr = (m_addr + 1) % 512;
    endtask

    task automatic zpu_read_check(input string tag);
        zpu_lba_sel = 1'b0;
        tick();
        chk(tag, zpu_in3, {24'h0, m_ram[m_addr]});
    endtask

    task automatic hps_read_check(input string tag, input int a);
        hps.sd_buff_addr = sector_addr_t'(a);
        tick();
        chk(tag, hps.sd_buff_din, m_ram[a]);
    endtask

    task automatic filesize_check(input string tag);
        zpu_lba_sel = 1'b1;
        #1;
        chk(tag, zpu_in3, m_fsize);
        zpu_lba_sel = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        logic [7:0]  rb;
        int          h;

        RESET_N = 1'b0;
        {zpu_lba_sel, zpu_block_rd, zpu_block_wr, zpu_io_wr, zpu_data_wr, zpu_data_rd} = '0;
        zpu_wdata = '0;
        hps.sd_ack = 1'b0; hps.sd_buff_addr = '0; hps.sd_buff_dout = '0; hps.sd_buff_wr = 1'b0;
        hps.img_mounted = 1'b0; hps.img_size = '0; hps.ioctl_index = '0;
        model_reset();

        // reset state and post-reset resync with an empty image
        tick(3);
        chk("rst_lba", hps.sd_lba, 0);
        chk("rst_rd", hps.sd_rd, 0);
        chk("rst_wr", hps.sd_wr, 0);
        chk("rst_in2", zpu_in2, 0);
        filesize_check("rst_fsize");
        RESET_N = 1'b1;
        tick();
        chk("resync_empty", zpu_in2, exp_in2());

        // sector read: hps acks 3 cycles later and fills the buffer
        zpu_block_rd = 1'b1;
        tick();
        chk("rd_latency", hps.sd_rd, 0);
        tick();
        chk("rd_req", hps.sd_rd, 1);
        chk("rd_in2", zpu_in2, exp_in2());
        zpu_block_rd = 1'b0;
        tick(3);
        chk("rd_held", hps.sd_rd, 1);
        hps.sd_ack = 1'b1;
        for (int i = 0; i < 512; i++) begin
            hps.sd_buff_addr = sector_addr_t'(i);
            hps.sd_buff_dout = 8'(i);
            hps.sd_buff_wr   = 1'b1;
            tick();
            m_ram[i] = 8'(i);
            if (i == 0) chk("rd_ack_drop", hps.sd_rd, 0);
        end
        hps.sd_buff_wr = 1'b0;
        chk("rd_done_busy", zpu_in2[0], 0);
        hps.sd_ack = 1'b0;
        tick();
        m_done = 1'b1;
        chk("rd_done", zpu_in2, exp_in2());

        for (int i = 0; i < 512; i++) begin
            zpu_read_check("sector_byte");
            zpu_rd_strobe($urandom_range(1, 3));
        end
        zpu_read_check("sector_wrap");

        // LBA writes: no buffer write, address untouched
        zpu_lba_sel = 1'b1;
        zpu_wdata   = 32'h0001_2345;
        zpu_data_wr = 1'b1;
        tick();
        chk("lba_before", hps.sd_lba, m_lba);
        tick();
        m_lba = 32'h0001_2345;
        chk("lba_t1", hps.sd_lba, m_lba);
        tick(2);
        zpu_data_wr = 1'b0;
        tick(3);
        zpu_read_check("lba_addr_kept");
        for (int k = 0; k < 3; k++) begin
            v = $urandom;
            h = $urandom_range(1, 5);
            zpu_lba_sel = 1'b1;
            zpu_wdata   = v;
            zpu_data_wr = 1'b1;
            tick(h);
            zpu_data_wr = 1'b0;
            tick(3);
            m_lba = v;
            chk("lba_rand", hps.sd_lba, m_lba);
        end
        zpu_read_check("lba_rand_addr");

        // buffer writes after clear, then clear racing a read falling edge
        zpu_rd_strobe(1);
        zpu_io_wr = 1'b1;
        tick();
        zpu_io_wr = 1'b0;
        m_addr = 0;
        zpu_write(8'hA1, $urandom_range(1, 4));
        zpu_write(8'hB2, $urandom_range(1, 4));
        zpu_write(8'hC3, $urandom_range(1, 4));
        for (int a = 0; a < 3; a++) hps_read_check("buf_wr", a);
        zpu_read_check("buf_addr3");
        zpu_data_rd = 1'b1;
        tick();
        zpu_data_rd = 1'b0;
        zpu_io_wr   = 1'b1;
        tick();
        zpu_io_wr   = 1'b0;
        m_addr = 0;
        zpu_read_check("clear_prio");
        for (int k = 0; k < 6; k++) begin
            rb = 8'($urandom);
            zpu_write(rb, $urandom_range(1, 4));
        end
        for (int a = 0; a < 6; a++) hps_read_check("buf_rand", a);

        // mount events
        hps.ioctl_index = 8'h80;
        hps.img_size    = 64'h4000;
        hps.img_mounted = 1'b1;
        tick();
        m_ro = 1'b1; m_ftype = 2'b10; m_fsize = 32'h4000; m_mounted = ~m_mounted;
        chk("mount1_in2", zpu_in2, exp_in2());
        filesize_check("mount1_fsize");
        hps.img_mounted = 1'b0;
        tick(2);
        hps.ioctl_index = 8'($urandom);
        hps.img_size    = {$urandom, $urandom};
        hps.img_mounted = 1'b1;
        tick();
        m_ftype = hps.ioctl_index[7:6]; m_fsize = hps.img_size[31:0]; m_mounted = ~m_mounted;
        chk("mount2_in2", zpu_in2, exp_in2());
        filesize_check("mount2_fsize");
        hps.img_mounted = 1'b0;
        tick(2);

        // simultaneous requests, then an ack swallowing a new write edge
        zpu_block_rd = 1'b1;
        zpu_block_wr = 1'b1;
        tick(2);
        m_done = 1'b0;
        chk("sim_rd", hps.sd_rd, 1);
        chk("sim_wr", hps.sd_wr, 0);
        chk("sim_in2", zpu_in2, exp_in2());
        zpu_block_rd = 1'b0;
        zpu_block_wr = 1'b0;
        tick(2);
        zpu_block_wr = 1'b1;
        tick();
        hps.sd_ack = 1'b1;
        tick();
        chk("ack_prio_rd", hps.sd_rd, 0);
        chk("ack_prio_wr", hps.sd_wr, 0);
        hps.sd_ack = 1'b0;
        tick();
        m_done = 1'b1;
        chk("ack_prio_wr2", hps.sd_wr, 0);
        chk("ack_prio_done", zpu_in2, exp_in2());
        zpu_block_wr = 1'b0;
        tick(2);

        // plain block write request
        zpu_block_wr = 1'b1;
        tick();
        chk("wr_latency", hps.sd_wr, 0);
        tick();
        m_done = 1'b0;
        chk("wr_req", hps.sd_wr, 1);
        chk("wr_req_rd", hps.sd_rd, 0);
        chk("wr_in2", zpu_in2, exp_in2());
        hps.sd_ack = 1'b1;
        tick();
        hps.sd_ack = 1'b0;
        tick();
        m_done = 1'b1;
        chk("wr_done", zpu_in2, exp_in2());
        zpu_block_wr = 1'b0;
        tick();

        // reset in the middle of a read request
        zpu_block_rd = 1'b1;
        tick(2);
        chk("mid_req", hps.sd_rd, 1);
        hps.img_size = 64'h200;
        RESET_N = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_rd", hps.sd_rd, 0);
        chk("mid_rst_lba", hps.sd_lba, 0);
        chk("mid_rst_in2", zpu_in2, exp_in2());
        filesize_check("mid_rst_fsize");
        zpu_block_rd = 1'b0;
        tick(2);
        RESET_N = 1'b1;
        tick();
        m_mounted = 1'b1;
        chk("resync_mounted", zpu_in2, exp_in2());
        chk("resync_rd", hps.sd_rd, 0);
        zpu_read_check("rst_addr");

        // resync coinciding with a mount edge: the toggle wins
        RESET_N = 1'b0;
        hps.img_size    = 64'h0;
        hps.ioctl_index = 8'h40;
        tick();
        model_reset();
        hps.img_mounted = 1'b1;
        RESET_N = 1'b1;
        tick();
        m_mounted = 1'b1; m_ro = 1'b1; m_ftype = 2'b01; m_fsize = 32'h0;
        chk("resync_vs_mount", zpu_in2, exp_in2());
        hps.img_mounted = 1'b0;
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
